// File: rtl/trng_csr_ctrl.sv
// TRNG control/status register block: BRAM-style CPU bus decode, entropy-source
// configuration and a timed sampling sequencer that whitens RO bits through an LFSR.
module trng_csr_ctrl #(
   parameter int                    addr_width    = 13,
   parameter int                    lfsr_width    = 12,
   parameter int                    tmw_width     = 12,
   parameter int                    num_ch        = 7,
   parameter logic [lfsr_width-1:0] lfsr_poly_rst = 'hE08
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [3:0]            we,
   input  logic [addr_width-1:0] addr,
   input  logic [31:0]           wrdata,
   input  logic [num_ch-1:0]     ro_i,
   output logic [31:0]           rdata,
   output logic                  irq_o
);

   localparam int idx_w = addr_width - 4;

   localparam logic [idx_w-1:0] reg_ctrl    = 1;
   localparam logic [idx_w-1:0] reg_seed    = 2;
   localparam logic [idx_w-1:0] reg_poly    = 3;
   localparam logic [idx_w-1:0] reg_tmw     = 4;
   localparam logic [idx_w-1:0] reg_tmw_max = 5;
   localparam logic [idx_w-1:0] reg_ro      = 6;
   localparam logic [idx_w-1:0] reg_status  = 7;
   localparam logic [idx_w-1:0] reg_result  = 8;

   typedef enum logic {st_idle, st_run} state_t;

   state_t                state;
   logic                  irq_en;
   logic                  mode;
   logic [4:0]            ch_sel;
   logic [lfsr_width-1:0] seed;
   logic [lfsr_width-1:0] poly;
   logic [lfsr_width-1:0] lfsr;
   logic [lfsr_width-1:0] result;
   logic [tmw_width-1:0]  tmw;
   logic [tmw_width-1:0]  tmw_max;
   logic                  done;
   logic                  err;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old_val;
      for (int k = 0; k < 4; k++)
         if (be[k]) r[8*k +: 8] = new_val[8*k +: 8];
      return r;
   endfunction

   logic [idx_w-1:0] idx;
   logic             busy;
   logic             wr;
   logic             sel_ctrl, sel_seed, sel_poly, sel_tmw_max, sel_status;
   logic             new_irq_en, new_mode;
   logic [4:0]       new_ch;
   logic             req, req_bad, start;
   logic             err_set, done_set, w1c_done, w1c_err;
   logic             done_nxt, err_nxt, irq_en_nxt;
   logic [31:0]      ro_ext;
   logic             sample_bit;
   logic [lfsr_width-1:0] lfsr_nxt;
   logic [tmw_width-1:0]  tmw_inc;
   logic [31:0]      rd_mux;
   logic             unused_addr_lsbs;

   // The low address nibble only selects bytes inside a 16-byte register slot.
   assign unused_addr_lsbs = ^addr[3:0];

   assign idx         = addr[addr_width-1:4];
   assign busy        = (state == st_run);
   assign wr          = en & (|we);
   assign sel_ctrl    = (idx == reg_ctrl);
   assign sel_seed    = (idx == reg_seed);
   assign sel_poly    = (idx == reg_poly);
   assign sel_tmw_max = (idx == reg_tmw_max);
   assign sel_status  = (idx == reg_status);

   // Start validity is judged against the configuration written in the same access.
   assign new_irq_en = we[0] ? wrdata[1]    : irq_en;
   assign new_mode   = we[0] ? wrdata[2]    : mode;
   assign new_ch     = we[1] ? wrdata[12:8] : ch_sel;

   assign req     = en & we[0] & wrdata[0] & sel_ctrl & ~busy;
   assign req_bad = (tmw_max == '0) | (~new_mode & ({27'd0, new_ch} >= 32'(num_ch)));
   assign start   = req & ~req_bad;

   assign err_set  = (req & req_bad) |
                     (busy & wr & (sel_ctrl | sel_seed | sel_poly | sel_tmw_max));
   assign tmw_inc  = tmw + tmw_width'(1);
   assign done_set = busy & (tmw_inc == tmw_max);
   assign w1c_done = wr & sel_status & we[0] & wrdata[1];
   assign w1c_err  = wr & sel_status & we[0] & wrdata[2];

   assign done_nxt   = done_set | (done & ~w1c_done & ~start);
   assign err_nxt    = err_set | (err & ~w1c_err);
   assign irq_en_nxt = (wr & sel_ctrl & ~busy) ? new_irq_en : irq_en;

   assign ro_ext     = 32'(ro_i);
   assign sample_bit = mode ? ^ro_i : ro_ext[ch_sel];
   assign lfsr_nxt   = {lfsr[lfsr_width-2:0], (^(lfsr & poly)) ^ sample_bit};

   always_comb begin
      // NOTE: default first so every path assigns rd_mux and no latch is inferred.
      rd_mux = '0;
      case (idx)
         reg_ctrl:    rd_mux = {19'd0, ch_sel, 5'd0, mode, irq_en, 1'b0};
         reg_seed:    rd_mux = 32'(seed);
         reg_poly:    rd_mux = 32'(poly);
         reg_tmw:     rd_mux = 32'(tmw);
         reg_tmw_max: rd_mux = 32'(tmw_max);
         reg_ro:      rd_mux = ro_ext;
         reg_status:  rd_mux = {29'd0, err, done, busy};
         reg_result:  rd_mux = 32'(result);
         default:     rd_mux = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= st_idle;
         irq_en  <= 1'b0;
         mode    <= 1'b0;
         ch_sel  <= '0;
         seed    <= '0;
         poly    <= lfsr_poly_rst;
         lfsr    <= '0;
         result  <= '0;
         tmw     <= '0;
         tmw_max <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         irq_o   <= 1'b0;
      end else begin
         done   <= done_nxt;
         err    <= err_nxt;
         irq_en <= irq_en_nxt;
         irq_o  <= done_nxt & irq_en_nxt;
         if (en) rdata <= rd_mux;

         if (wr && !busy) begin
            if (sel_ctrl) begin
               mode   <= new_mode;
               ch_sel <= new_ch;
            end
            if (sel_seed)    seed    <= lfsr_width'(byte_merge(32'(seed), wrdata, we));
            if (sel_poly)    poly    <= lfsr_width'(byte_merge(32'(poly), wrdata, we));
            if (sel_tmw_max) tmw_max <= tmw_width'(byte_merge(32'(tmw_max), wrdata, we));
         end

         case (state)
            st_idle: begin
               if (start) begin
                  lfsr  <= seed;
                  tmw   <= '0;
                  state <= st_run;
               end
            end
            st_run: begin
               lfsr <= lfsr_nxt;
               tmw  <= tmw_inc;
               if (tmw_inc == tmw_max) begin
                  result <= lfsr_nxt;
                  state  <= st_idle;
               end
            end
            default: state <= st_idle;
         endcase
      end
   end

endmodule

// File: doc/trng_csr_ctrl.md
# trng_csr_ctrl

Parametrised control/status register block with an embedded sampling sequencer for the TRNG. It decodes the BRAM-style CPU bus (en / byte-enable we / addr / wrdata / registered rdata) and holds the entropy-source configuration. On request it runs a timed sampling window that folds raw ring-oscillator bits into an LFSR whitener, then latches the result and raises a done flag and an optional interrupt.

## Interface
- addr_width, 13: byte address width; register index is addr[addr_width-1:4], 16-byte stride; addr[3:0] ignored.
- lfsr_width, 12: LFSR / seed / poly / result width (≤ 32).
- tmw_width, 12: sampling-window counter and TMW_MAX width (≤ 32).
- num_ch, 7: number of ring-oscillator channels (1..32).
- lfsr_poly_rst, 'hE08: reset value of LFSR_POLY.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  bus access strobe.
- we  in  4  byte write enables; we[k] writes wrdata[8k+7:8k]; we==0 with en=1 is a read.
- addr  in  addr_width  byte address.
- wrdata  in  32  write data.
- ro_i  in  num_ch  raw RO bits, already synchronised to clk.
- rdata  out  32  registered read data.
- irq_o  out  1  done & irq_en, driven from flops.

## Operation
- Register map (index: name, access, fields); unimplemented bits read 0, unmapped indices read 0 and ignore writes:
  - 1 CTRL RW: [0] request (write-1 pulse, reads 0), [1] irq_en, [2] mode (0 single channel, 1 XOR of all ro_i), [12:8] ch_sel.
  - 2 LFSR_SEED RW, lfsr_width.
  - 3 LFSR_POLY RW, lfsr_width, tap mask.
  - 4 TMW RO: samples taken in current/last window.
  - 5 TMW_MAX RW, tmw_width: window length in cycles.
  - 6 RO RO: live ro_i.
  - 7 STATUS: [0] busy RO, [1] done W1C sticky, [2] err W1C sticky.
  - 8 RESULT RO, lfsr_width.
- FSM IDLE -> RUN -> IDLE. Start condition: en & we[0] & wrdata[0] at index 1, in IDLE.
- Start rejected (stay IDLE, set err) if TMW_MAX == 0, or mode=0 and ch_sel ≥ num_ch. CTRL bits [2:1],[12:8] still written that cycle.
- On accepted start: lfsr <= LFSR_SEED, TMW <= 0, busy=1, done cleared.
- Each RUN cycle: b = mode ? ^ro_i : ro_i[ch_sel]; lfsr <= {lfsr[W-2:0], ^(lfsr & poly) ^ b}; TMW += 1.
- When TMW reaches TMW_MAX: RESULT <= final lfsr, done=1, busy=0, return to IDLE.
- While busy: request, writes to CTRL, SEED, POLY, TMW_MAX are ignored and set err; STATUS W1C still works.
- Reset: all registers 0 except LFSR_POLY = lfsr_poly_rst; FSM IDLE; rdata=0; irq_o=0. Reset mid-RUN aborts, RESULT=0, no done.

## Timing
- Read: en=1, we=0 at cycle T -> rdata valid at T+1 with register value sampled at T (pre-edge). en=0 -> rdata holds.
- Write with en=1 returns previous value on rdata at T+1.
- Start write at T -> busy=1 at T+1; samples taken at T+1..T+TMW_MAX; RESULT, done, busy=0 at T+TMW_MAX+1; irq_o same cycle if irq_en.
- done set and W1C in same cycle: set wins. err set and W1C same cycle: set wins.
- TMW saturates at TMW_MAX; never wraps.

## Test plan
- Reset -> all reads 0 except LFSR_POLY = 'hE08; irq_o=0; rdata=0.
- SEED='h001, POLY='hE08, TMW_MAX=1, ro_i=0, mode 0 ch 0, request -> busy 1 cycle, RESULT='h002, done=1, TMW=1.
- Same with ro_i[0]=1 and irq_en=1 -> RESULT='h003, irq_o=1 at T+2; W1C done -> irq_o=0 next cycle.
- TMW_MAX=0 request -> no busy, err=1; ch_sel=7 with num_ch=7 -> err=1; write STATUS 'h4 -> err=0.
- Start with TMW_MAX=100, write SEED at cycle 10 -> SEED unchanged, err=1, run completes at T+101; byte write we='b0001 to TMW_MAX='hABC->data 'h0FF -> TMW_MAX='hAFF.
- Assert rst at cycle 50 of a 100-cycle window -> busy=0, done=0, RESULT=0, POLY='hE08 next cycle.
